pin_input_conditioner: RTL and testbench

Input-direction counterpart of the top-level pin tri-state output path. Brings the 32 asynchronous Propeller I/O pins into the clock_80 domain through a multi-stage synchronizer, then applies an optional per-pin glitch filter and generates per-pin edge pulses. Produces the input bus fed to p1v's pin_in, with output-driven pins looped back directly. Sits between the board pads and p1v in each board top-level.

---
 rtl/pin_input_conditioner.sv | 109 ++++++++++
 tb/tb_pin_input_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pin_input_conditioner.sv
// Pad input conditioning: multi-stage synchronizer, optional per-pin glitch
// filter, per-pin edge pulses, loopback of driven pins and a saturating
// count of cycles in which a glitch was rejected.

module pin_cond_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 8,
  parameter logic INIT_BIT    = 1'b0
) (
  input  logic clock_80,
  input  logic res,
  input  logic pad,
  input  logic filter_en,
  output logic filt,
  output logic filt_q,
  output logic glitch
);
  localparam int            CW   = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] s;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = s[SYNC_STAGES-1];

  // A count that dies before reaching the accept point is a rejected glitch.
  assign glitch = filter_en && (sync == filt) && (cnt != '0);

  // Plain flop chain into the clock_80 domain; nothing between stages.
  always_ff @(posedge clock_80) begin
    if (res) s <= {SYNC_STAGES{INIT_BIT}};
    else     s <= {s[SYNC_STAGES-2:0], pad};
  end

  // Accept a new level after FILTER_LEN consecutive differing samples;
  // with the filter off the synchronized level passes straight through.
  always_ff @(posedge clock_80) begin
    if (res) begin
      filt   <= INIT_BIT;
      filt_q <= INIT_BIT;
      cnt    <= '0;
    end else begin
      filt_q <= filt;
      if (!filter_en) begin
        filt <= sync;
        cnt  <= '0;
      end else if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module pin_input_conditioner #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 8,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             clock_80,
  input  logic             res,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] pin_out,
  input  logic [WIDTH-1:0] pin_dir,
  input  logic [WIDTH-1:0] filter_en,
  input  logic             glitch_clr,
  output logic [WIDTH-1:0] prop_input_bus,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [15:0]      glitch_count
);
  logic [WIDTH-1:0] filt, filt_q, glitch;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pin_cond_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .INIT_BIT   (INIT[i])
    ) u_lane (
      .clock_80 (clock_80),
      .res      (res),
      .pad      (pin_in[i]),
      .filter_en(filter_en[i]),
      .filt     (filt[i]),
      .filt_q   (filt_q[i]),
      .glitch   (glitch[i])
    );
  end

  assign rise    = filt & ~filt_q;
  assign fall    = ~filt & filt_q;
  assign changed = |(rise | fall);

  // Driven pins loop back with zero latency, bypassing the synchronizer.
  assign prop_input_bus = (pin_dir & pin_out) | (~pin_dir & filt);

  // One increment per cycle with any rejection; clear beats increment.
  always_ff @(posedge clock_80) begin
    if (res || glitch_clr)                    glitch_count <= '0;
    else if (|glitch && glitch_count != '1)   glitch_count <= glitch_count + 16'd1;
  end
endmodule

// File: tb/tb_pin_input_conditioner.sv
// Scoreboard bench: stimulus queues expected edge pulses with their cycle,
// a monitor pops and compares whenever the DUT flags a change.

module tb_pin_input_conditioner;
  logic        clock_80 = 1'b0;
  logic        res;
  logic [31:0] pin_in, pin_out, pin_dir, filter_en;
  logic        glitch_clr;
  logic [31:0] prop_input_bus, rise, fall;
  logic        changed;
  logic [15:0] glitch_count;

  pin_input_conditioner dut (
    .clock_80      (clock_80),
    .res           (res),
    .pin_in        (pin_in),
    .pin_out       (pin_out),
    .pin_dir       (pin_dir),
    .filter_en     (filter_en),
    .glitch_clr    (glitch_clr),
    .prop_input_bus(prop_input_bus),
    .rise          (rise),
    .fall          (fall),
    .changed       (changed),
    .glitch_count  (glitch_count)
  );

  always #5 clock_80 = ~clock_80;

  typedef struct {
    int          cyc;
    logic [31:0] r;
    logic [31:0] f;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_pass = 0;

  always @(posedge clock_80) cyc++;

  task automatic step(int n);
    repeat (n) @(negedge clock_80);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(int c, logic [31:0] r, logic [31:0] f);
    ev_t e;
    e.cyc = c; e.r = r; e.f = f;
    q.push_back(e);
  endtask

  // Monitor: every flagged change must match the head of the scoreboard.
  always @(negedge clock_80) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      $display("FAIL missed_edge: no pulse at cycle %0d expected rise %h fall %h",
               q[0].cyc, q[0].r, q[0].f);
      void'(q.pop_front());
    end
    if (changed) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_chk++;
        $display("FAIL extra_edge: rise %h fall %h at cycle %0d, none expected", rise, fall, cyc);
      end else begin
        chk("edge_rise", rise, q[0].r);
        chk("edge_fall", fall, q[0].f);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    res = 1'b1; pin_in = '0; pin_out = '0; pin_dir = '0; filter_en = '0; glitch_clr = 1'b0;
    step(3);
    res = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_bus", prop_input_bus, 32'h0);
      chk("idle_gc", {16'h0, glitch_count}, 32'h0);
    end

    // Unfiltered path: edge lands SYNC_STAGES+1 edges after the pad change.
    pin_in[3] = 1'b1; push(cyc + 3, 32'h8, 32'h0); step(8);
    chk("nofilt_bus", prop_input_bus, 32'h8);
    pin_in[3] = 1'b0; push(cyc + 3, 32'h0, 32'h8); step(8);
    pin_in = 32'h18;  push(cyc + 3, 32'h18, 32'h0); step(8);
    pin_in = 32'h0;   push(cyc + 3, 32'h0, 32'h18); step(8);

    // Filtered pin 5: short pulses rejected, 8+ accepted after 10 edges.
    filter_en = 32'h20;
    pin_in[5] = 1'b1; step(5); pin_in[5] = 1'b0; step(14);
    chk("glitch5", {16'h0, glitch_count}, 32'd1);
    pin_in[5] = 1'b1; step(7); pin_in[5] = 1'b0; step(14);
    chk("glitch7", {16'h0, glitch_count}, 32'd2);
    c0 = cyc; pin_in[5] = 1'b1; push(c0 + 10, 32'h20, 32'h0);
    step(8); pin_in[5] = 1'b0; push(c0 + 18, 32'h0, 32'h20); step(14);
    c0 = cyc; pin_in[5] = 1'b1; push(c0 + 10, 32'h20, 32'h0);
    step(12); pin_in[5] = 1'b0; push(c0 + 22, 32'h0, 32'h20); step(14);
    chk("accept_no_glitch", {16'h0, glitch_count}, 32'd2);

    // Disable mid-count: pending count dropped, filt takes sync next edge.
    pin_in[5] = 1'b1; step(5);
    filter_en[5] = 1'b0; push(cyc + 1, 32'h20, 32'h0); step(6);
    chk("disable_bus", prop_input_bus, 32'h20);
    pin_in[5] = 1'b0; push(cyc + 3, 32'h0, 32'h20); step(6);
    filter_en[5] = 1'b1;
    chk("disable_gc", {16'h0, glitch_count}, 32'd2);

    // Loopback of a driven pin, undriven pins masked from pin_out.
    pin_dir = 32'h80;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = (i % 2 == 1) ? 32'h80 : 32'h0;
      pin_out = 32'hFFFF_FF7F | v;
      #1 chk("loopback", prop_input_bus, v);
      step(1);
    end
    pin_dir = '0; pin_out = '0;

    // Saturation: two pins glitching in alternate phases -> one per cycle.
    filter_en = 32'h23;
    glitch_clr = 1'b1; step(1); glitch_clr = 1'b0;
    chk("clr", {16'h0, glitch_count}, 32'd0);
    for (int i = 0; i < 66000; i++) begin
      pin_in[0] = i[0]; pin_in[1] = ~i[0]; step(1);
    end
    chk("saturate", {16'h0, glitch_count}, 32'h0000_FFFF);
    pin_in[0] = 1'b0; pin_in[1] = 1'b1; glitch_clr = 1'b1; step(1);
    chk("clr_wins", {16'h0, glitch_count}, 32'd0);
    pin_in[0] = 1'b1; pin_in[1] = 1'b0; glitch_clr = 1'b0; step(1);
    chk("count_one", {16'h0, glitch_count}, 32'd1);
    pin_in = '0; step(12);

    // Reset with cnt[5] = 6: no pulse at release, re-accepted 10 edges later.
    filter_en = 32'h20;
    pin_in[5] = 1'b1; step(8);
    res = 1'b1; step(1); res = 1'b0;
    push(cyc + 10, 32'h20, 32'h0);
    step(1);
    chk("rst_filt", prop_input_bus, 32'h0);
    chk("rst_gc", {16'h0, glitch_count}, 32'd0);
    step(13);
    chk("rst_accept", prop_input_bus, 32'h20);
    pin_in[5] = 1'b0; push(cyc + 10, 32'h0, 32'h20); step(14);

    step(3);
    while (q.size() > 0) begin
      n_chk++;
      $display("FAIL pending_edge: cycle %0d rise %h fall %h never seen", q[0].cyc, q[0].r, q[0].f);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
